// File: rtl/pixel_phase_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : pixel_phase_pkg                                             |
// | Description : Shared state encoding and phase one-hot constants for the   |
// |               pixel phase sequencer.                                      |
// | Revision    : 1.0 - initial release                                       |
// ---------------------------------------------------------------------------
package pixel_phase_pkg;

  // ST_GAP only becomes reachable in the PPS_NONOVERLAP_EN build, but it is
  // always part of the encoding so both builds share one state type.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_PRE   = 3'd2,
    ST_INT   = 3'd3,
    ST_L1    = 3'd4,
    ST_L2    = 3'd5,
    ST_DONE  = 3'd6,
    ST_GAP   = 3'd7
  } pps_state_e;

  // Phase vector ordering: {phi_r, phi_p, phi_l1, phi_l2}
  localparam logic [3:0] PHI_NONE = 4'b0000;
  localparam logic [3:0] PHI_R    = 4'b1000;
  localparam logic [3:0] PHI_P    = 4'b0100;
  localparam logic [3:0] PHI_L1   = 4'b0010;
  localparam logic [3:0] PHI_L2   = 4'b0001;

  function automatic logic [3:0] phase_of(input pps_state_e s);
    case (s)
      ST_RESET: return PHI_R;
      ST_PRE:   return PHI_P;
      ST_L1:    return PHI_L1;
      ST_L2:    return PHI_L2;
      default:  return PHI_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_phase_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : pixel_phase_sequencer_if                                    |
// | Description : Configuration inputs and pad-side phase outputs of the      |
// |               pixel phase sequencer. The master drives configuration, the |
// |               slave (sequencer) drives the phases and status.             |
// | Revision    : 1.0 - initial release                                       |
// ---------------------------------------------------------------------------
interface pixel_phase_sequencer_if #(
  parameter int N_PIX = 16,
  parameter int CNT_W = 8,
  parameter int DIV_W = 4
);
  localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;

  logic             i_enable;
  logic [DIV_W-1:0] i_freq_sel;
  logic [CNT_W-1:0] i_t_reset;
  logic [CNT_W-1:0] i_t_pre;
  logic [CNT_W-1:0] i_t_int;
  logic [CNT_W-1:0] i_t_l1;
  logic [CNT_W-1:0] i_t_l2;

  logic             o_phi_r;
  logic             o_phi_p;
  logic             o_phi_l1;
  logic             o_phi_l2;
  logic             o_adc_frame;
  logic             o_pixel_flag;
  logic [IDX_W-1:0] o_pixel_idx;
  logic             o_busy;
  logic             o_frame_done;

  modport master (
    output i_enable, i_freq_sel, i_t_reset, i_t_pre, i_t_int, i_t_l1, i_t_l2,
    input  o_phi_r, o_phi_p, o_phi_l1, o_phi_l2, o_adc_frame, o_pixel_flag,
           o_pixel_idx, o_busy, o_frame_done
  );

  modport slave (
    input  i_enable, i_freq_sel, i_t_reset, i_t_pre, i_t_int, i_t_l1, i_t_l2,
    output o_phi_r, o_phi_p, o_phi_l1, o_phi_l2, o_adc_frame, o_pixel_flag,
           o_pixel_idx, o_busy, o_frame_done
  );

endinterface
`default_nettype wire

// File: rtl/pixel_phase_sequencer_tick_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : phase_tick_divider                                          |
// | Description : Counts 0..D and emits a registered one-cycle tick on the    |
// |               last count. A synchronous clear restarts the count at 0.    |
// |               o_tick_next is the value o_tick will take next cycle, so    |
// |               the parent can register outputs that look one cycle ahead.  |
// | Revision    : 1.0 - initial release                                       |
// ---------------------------------------------------------------------------
module phase_tick_divider #(
  parameter int DIV_W = 4
) (
  input  logic             i_clock,
  input  logic             i_rst_n,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_clear,
  output logic             o_tick,
  output logic             o_tick_next
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  // Next count: wrap at D or restart on clear; tick follows the next count
  always_comb begin
    cnt_d       = (i_clear || (cnt_q == i_div)) ? '0 : cnt_q + DIV_W'(1);
    o_tick_next = (cnt_d == i_div);
  end

  // Count and tick registers
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= o_tick_next;
    end
  end

  assign o_tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/pixel_phase_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : pixel_phase_sequencer                                       |
// | Description : Generates phi_r/phi_p/phi_l1/phi_l2 per pixel for a frame   |
// |               of N_PIX pixels with programmable tick rate and durations,  |
// |               plus an ADC frame envelope. Optional macro                  |
// |               PPS_NONOVERLAP_EN inserts a one-tick low GAP after RESET,   |
// |               PRE, L1 and L2.                                             |
// | Revision    : 1.0 - initial release                                       |
// ---------------------------------------------------------------------------
module pixel_phase_sequencer
  import pixel_phase_pkg::*;
#(
  parameter int N_PIX = 16,
  parameter int CNT_W = 8,
  parameter int DIV_W = 4
) (
  input  logic                   i_clock,
  input  logic                   i_rst_n,
  pixel_phase_sequencer_if.slave bus
);

  localparam int               IDX_W    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  pps_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] ph_q, ph_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] tr_q, tr_d, tp_q, tp_d, ti_q, ti_d, tl1_q, tl1_d, tl2_q, tl2_d;
  logic [3:0]       phi_q, phi_d;
  logic             adc_q, adc_d;
  logic             flag_q, flag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             clear;
  logic             latch;
  logic             leave;
  logic             last_pix;
  logic             last_next;
  logic [CNT_W-1:0] lim_cur;
  logic [CNT_W-1:0] lim_next;
  logic             tick;
  logic             tick_next;

`ifdef PPS_NONOVERLAP_EN
  // State the current GAP was entered from; decides where the GAP exits to
  pps_state_e       from_q, from_d;
`endif

  // Zero-length durations behave as one tick
  function automatic logic [CNT_W-1:0] sat1(input logic [CNT_W-1:0] t);
    return (t == '0) ? ONE : t;
  endfunction

  function automatic logic [CNT_W-1:0] lim_of(
    input pps_state_e       s,
    input logic [CNT_W-1:0] t_r,
    input logic [CNT_W-1:0] t_p,
    input logic [CNT_W-1:0] t_i,
    input logic [CNT_W-1:0] t_1,
    input logic [CNT_W-1:0] t_2
  );
    case (s)
      ST_RESET: return t_r;
      ST_PRE:   return t_p;
      ST_INT:   return t_i;
      ST_L1:    return t_1;
      ST_L2:    return t_2;
      default:  return ONE;
    endcase
  endfunction

  // Divider sees the configuration that will be live next cycle, so its
  // lookahead tick is correct on the very first cycle of a new frame.
  phase_tick_divider #(
    .DIV_W(DIV_W)
  ) u_tick_div (
    .i_clock    (i_clock),
    .i_rst_n    (i_rst_n),
    .i_div      (div_d),
    .i_clear    (clear),
    .o_tick     (tick),
    .o_tick_next(tick_next)
  );

  // Next-state logic: a timed state is left on the tick where its count completes
  always_comb begin
    state_d  = state_q;
`ifdef PPS_NONOVERLAP_EN
    from_d   = from_q;
`endif
    lim_cur  = lim_of(state_q, tr_q, tp_q, ti_q, tl1_q, tl2_q);
    leave    = tick && (ph_q == (lim_cur - ONE));
    last_pix = (idx_q == LAST_IDX);

    case (state_q)
      ST_IDLE: begin
        if (bus.i_enable) state_d = ST_RESET;
      end
      ST_RESET: begin
        if (leave) begin
`ifdef PPS_NONOVERLAP_EN
          state_d = ST_GAP;
          from_d  = ST_RESET;
`else
          state_d = ST_PRE;
`endif
        end
      end
      ST_PRE: begin
        if (leave) begin
`ifdef PPS_NONOVERLAP_EN
          state_d = ST_GAP;
          from_d  = ST_PRE;
`else
          state_d = ST_INT;
`endif
        end
      end
      ST_INT: begin
        if (leave) state_d = ST_L1;
      end
      ST_L1: begin
        if (leave) begin
`ifdef PPS_NONOVERLAP_EN
          state_d = ST_GAP;
          from_d  = ST_L1;
`else
          state_d = ST_L2;
`endif
        end
      end
      ST_L2: begin
        if (leave) begin
`ifdef PPS_NONOVERLAP_EN
          state_d = ST_GAP;
          from_d  = ST_L2;
`else
          state_d = last_pix ? ST_DONE : ST_RESET;
`endif
        end
      end
      ST_GAP: begin
`ifdef PPS_NONOVERLAP_EN
        if (leave) begin
          case (from_q)
            ST_RESET: state_d = ST_PRE;
            ST_PRE:   state_d = ST_INT;
            ST_L1:    state_d = ST_L2;
            default:  state_d = last_pix ? ST_DONE : ST_RESET;
          endcase
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        state_d = bus.i_enable ? ST_RESET : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output lookahead, all derived from state_d
  always_comb begin
    clear = (state_d != state_q);
    latch = (state_d == ST_RESET) && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    div_d = latch ? bus.i_freq_sel      : div_q;
    tr_d  = latch ? sat1(bus.i_t_reset) : tr_q;
    tp_d  = latch ? sat1(bus.i_t_pre)   : tp_q;
    ti_d  = latch ? sat1(bus.i_t_int)   : ti_q;
    tl1_d = latch ? sat1(bus.i_t_l1)    : tl1_q;
    tl2_d = latch ? sat1(bus.i_t_l2)    : tl2_q;

    ph_d = clear ? '0 : (tick ? (ph_q + ONE) : ph_q);

    idx_d = idx_q;
    if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
      idx_d = '0;
    end else if ((state_d == ST_RESET) && ((state_q == ST_L2) || (state_q == ST_GAP))) begin
      idx_d = idx_q + IDX_W'(1);
    end

    // True when the cycle after this edge is the final cycle of state_d
    lim_next  = lim_of(state_d, tr_d, tp_d, ti_d, tl1_d, tl2_d);
    last_next = tick_next && (ph_d == (lim_next - ONE));

    phi_d  = phase_of(state_d);
    adc_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
`ifdef PPS_NONOVERLAP_EN
    flag_d = (state_d == ST_GAP) && (from_d == ST_L2) && last_next;
`else
    flag_d = (state_d == ST_L2) && last_next;
`endif
  end

  // State, configuration and output registers
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ph_q    <= '0;
      div_q   <= '0;
      tr_q    <= ONE;
      tp_q    <= ONE;
      ti_q    <= ONE;
      tl1_q   <= ONE;
      tl2_q   <= ONE;
      phi_q   <= PHI_NONE;
      adc_q   <= 1'b0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      div_q   <= div_d;
      tr_q    <= tr_d;
      tp_q    <= tp_d;
      ti_q    <= ti_d;
      tl1_q   <= tl1_d;
      tl2_q   <= tl2_d;
      phi_q   <= phi_d;
      adc_q   <= adc_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef PPS_NONOVERLAP_EN
  // Origin of the active GAP
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      from_q <= ST_IDLE;
    end else begin
      from_q <= from_d;
    end
  end
`endif

  assign bus.o_phi_r      = phi_q[3];
  assign bus.o_phi_p      = phi_q[2];
  assign bus.o_phi_l1     = phi_q[1];
  assign bus.o_phi_l2     = phi_q[0];
  assign bus.o_adc_frame  = adc_q;
  assign bus.o_pixel_flag = flag_q;
  assign bus.o_pixel_idx  = idx_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_phase_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : tb_pixel_phase_sequencer                                    |
// | Description : Scoreboard bench. Directed frames push expected output runs |
// |               (pattern, length) and event cycles; a monitor compares them |
// |               against what the sequencer actually produces.              |
// | Revision    : 1.0 - initial release                                       |
// ---------------------------------------------------------------------------
module tb_pixel_phase_sequencer;

  localparam int N_PIX = 2;
  localparam int CNT_W = 8;
  localparam int DIV_W = 4;
  localparam int IDX_W = 1;
`ifdef PPS_NONOVERLAP_EN
  localparam bit NONOV = 1'b1;
`else
  localparam bit NONOV = 1'b0;
`endif

  // {busy, adc, phi_r, phi_p, phi_l1, phi_l2, pixel_flag, frame_done, idx}
  typedef logic [8+IDX_W-1:0] vec_t;
  typedef struct { vec_t v; int len; } seg_t;
  typedef struct { int kind; int cyc; } evt_t;  // kind 0 = pixel flag, 1 = frame done

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_phase_sequencer_if #(.N_PIX(N_PIX), .CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

  pixel_phase_sequencer #(.N_PIX(N_PIX), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .i_clock(clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  seg_t seg_q[$];
  evt_t evt_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endfunction

  function automatic vec_t dut_vec();
    return {bus.o_busy, bus.o_adc_frame, bus.o_phi_r, bus.o_phi_p, bus.o_phi_l1,
            bus.o_phi_l2, bus.o_pixel_flag, bus.o_frame_done, bus.o_pixel_idx};
  endfunction

  function automatic vec_t mk(input bit busy, input bit adc, input logic [3:0] ph,
                              input bit flag, input bit done, input int idx);
    logic [IDX_W-1:0] ix;
    ix = IDX_W'(idx);
    return {busy, adc, ph, flag, done, ix};
  endfunction

  function automatic int sat(input int t);
    return (t < 1) ? 1 : t;
  endfunction

  // Adjacent runs with identical patterns appear as one run on the outputs
  function automatic void push_seg(input vec_t v, input int len);
    if (len <= 0) return;
    if (seg_q.size() > 0 && seg_q[seg_q.size()-1].v == v)
      seg_q[seg_q.size()-1].len += len;
    else
      seg_q.push_back('{v: v, len: len});
  endfunction

  task automatic push_frame(input int d, input int tr, input int tp, input int ti,
                            input int tl1, input int tl2);
    int   u;
    vec_t g;
    u = d + 1;
    for (int i = 0; i < N_PIX; i++) begin
      g = mk(1, 1, 4'b0000, 0, 0, i);
      push_seg(mk(1, 1, 4'b1000, 0, 0, i), sat(tr) * u);
      if (NONOV) push_seg(g, u);
      push_seg(mk(1, 1, 4'b0100, 0, 0, i), sat(tp) * u);
      if (NONOV) push_seg(g, u);
      push_seg(g, sat(ti) * u);
      push_seg(mk(1, 1, 4'b0010, 0, 0, i), sat(tl1) * u);
      if (NONOV) push_seg(g, u);
      if (NONOV) begin
        push_seg(mk(1, 1, 4'b0001, 0, 0, i), sat(tl2) * u);
        push_seg(g, u - 1);
        push_seg(mk(1, 1, 4'b0000, 1, 0, i), 1);
      end else begin
        push_seg(mk(1, 1, 4'b0001, 0, 0, i), sat(tl2) * u - 1);
        push_seg(mk(1, 1, 4'b0001, 1, 0, i), 1);
      end
    end
    push_seg(mk(1, 0, 4'b0000, 0, 1, 0), 1);
  endtask

  // pp = hand-computed cycles per pixel; flags at k*pp, done at N_PIX*pp+1
  task automatic push_events(input int pp);
    for (int i = 0; i < N_PIX; i++) evt_q.push_back('{kind: 0, cyc: (i + 1) * pp});
    evt_q.push_back('{kind: 1, cyc: N_PIX * pp + 1});
  endtask

  task automatic set_cfg(input int d, input int tr, input int tp, input int ti,
                         input int tl1, input int tl2);
    bus.i_freq_sel = DIV_W'(d);
    bus.i_t_reset  = CNT_W'(tr);
    bus.i_t_pre    = CNT_W'(tp);
    bus.i_t_int    = CNT_W'(ti);
    bus.i_t_l1     = CNT_W'(tl1);
    bus.i_t_l2     = CNT_W'(tl2);
  endtask

  task automatic pulse_enable();
    @(negedge clk);
    bus.i_enable = 1'b1;
    @(negedge clk);
    bus.i_enable = 1'b0;
  endtask

  task automatic wait_until(input int sel, input string name);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 3000) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       hit = bus.o_frame_done;
        1:       hit = bus.o_busy && (bus.o_pixel_idx == IDX_W'(1));
        2:       hit = !bus.o_busy;
        default: hit = bus.o_phi_l1 && (bus.o_pixel_idx == IDX_W'(1));
      endcase
    end
    chk({"wait_", name}, 32'(hit), 32'd1);
  endtask

  task automatic drain(input string name);
    repeat (2) @(negedge clk);
    chk({name, "_segments_drained"}, 32'(seg_q.size()), 32'd0);
    chk({name, "_events_drained"}, 32'(evt_q.size()), 32'd0);
  endtask

  // Monitor: run-length encodes the output vector and scores each finished run
  vec_t mon_run_v;
  int   mon_run_len;
  bit   mon_have_run = 1'b0;
  int   mon_fcyc = 0;
  bit   mon_prev_adc = 1'b0;
  vec_t mon_cur;
  evt_t mon_e;
  seg_t mon_s;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_have_run = 1'b0;
        mon_prev_adc = 1'b0;
        mon_fcyc     = 0;
      end else begin
        mon_cur = dut_vec();
        if (bus.o_phi_r && bus.o_pixel_idx == '0 && !mon_prev_adc) mon_fcyc = 1;
        else if (mon_fcyc > 0) mon_fcyc++;
        mon_prev_adc = bus.o_adc_frame;

        if (bus.o_pixel_flag || bus.o_frame_done) begin
          chk("event_expected", 32'(evt_q.size() > 0), 32'd1);
          if (evt_q.size() > 0) begin
            mon_e = evt_q.pop_front();
            chk(mon_e.kind == 1 ? "frame_done_cycle" : "pixel_flag_cycle",
                32'(mon_fcyc), 32'(mon_e.cyc));
            chk("event_kind", 32'(bus.o_frame_done), 32'(mon_e.kind));
          end
        end

        if (mon_have_run && mon_cur == mon_run_v) begin
          mon_run_len++;
        end else begin
          if (mon_have_run) begin
            chk("segment_expected", 32'(seg_q.size() > 0), 32'd1);
            if (seg_q.size() > 0) begin
              mon_s = seg_q.pop_front();
              chk("segment_pattern", 32'(mon_run_v), 32'(mon_s.v));
              chk("segment_length", 32'(mon_run_len), 32'(mon_s.len));
            end
          end
          if (mon_cur == '0) begin
            mon_have_run = 1'b0;
          end else begin
            mon_run_v    = mon_cur;
            mon_run_len  = 1;
            mon_have_run = 1'b1;
          end
        end
      end
    end
  end

  int busy_cycles;

  initial begin
    bus.i_enable = 1'b0;
    set_cfg(0, 2, 1, 3, 1, 2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("outputs_in_reset", 32'(dut_vec()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("outputs_idle_after_reset", 32'(dut_vec()), 32'd0);

    // Single frame, D=0, t=(2,1,3,1,2)
    set_cfg(0, 2, 1, 3, 1, 2);
    push_frame(0, 2, 1, 3, 1, 2);
    push_events(NONOV ? 13 : 9);
    pulse_enable();
    wait_until(2, "frame_d0_end");
    drain("frame_d0");

    // Same durations, D=1
    set_cfg(1, 2, 1, 3, 1, 2);
    push_frame(1, 2, 1, 3, 1, 2);
    push_events(NONOV ? 26 : 18);
    pulse_enable();
    wait_until(2, "frame_d1_end");
    drain("frame_d1");

    // Zero pre duration behaves as one tick, D=1
    set_cfg(1, 1, 0, 1, 1, 1);
    push_frame(1, 1, 0, 1, 1, 1);
    push_events(NONOV ? 18 : 10);
    pulse_enable();
    wait_until(2, "frame_tpre0_end");
    drain("frame_tpre0");

    // Continuous mode; t_reset change mid-frame lands in the following frame
    set_cfg(0, 2, 1, 3, 1, 2);
    push_frame(0, 2, 1, 3, 1, 2);
    push_events(NONOV ? 13 : 9);
    push_frame(0, 3, 1, 3, 1, 2);
    push_events(NONOV ? 14 : 10);
    @(negedge clk);
    bus.i_enable = 1'b1;
    wait_until(1, "cont_f1_pixel1");
    bus.i_t_reset = CNT_W'(3);
    wait_until(0, "cont_f1_done");
    wait_until(1, "cont_f2_pixel1");
    bus.i_enable = 1'b0;
    wait_until(2, "cont_end");
    drain("continuous");

    // Asynchronous reset during L1 of pixel 1
    set_cfg(0, 2, 1, 3, 1, 2);
    push_frame(0, 2, 1, 3, 1, 2);
    push_events(NONOV ? 13 : 9);
    pulse_enable();
    wait_until(3, "l1_pixel1");
    #2;
    rst_n = 1'b0;
    #1;
    chk("outputs_async_reset", 32'(dut_vec()), 32'd0);
    seg_q.delete();
    evt_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_cycles = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_busy) busy_cycles++;
    end
    chk("idle_after_reset_release_busy_cycles", 32'(busy_cycles), 32'd0);
    chk("idle_after_reset_release_outputs", 32'(dut_vec()), 32'd0);
    drain("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
